// File: rtl/matrix_stream_tx.sv
// matrix_stream_tx: streams a ROWS x COLS matrix row-major over AXIS with a 2-entry prefetch buffer.
// Define MATRIX_STREAM_TX_ROW_TLAST_EN to mark TLAST at the end of every row instead of once per matrix.
module matrix_stream_tx #(
    parameter int OUTW = 24,
    parameter int ROWS = 4,
    parameter int COLS = 4,
    localparam int NUM = ROWS * COLS,
    localparam int ADDRW = $clog2(NUM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [ADDRW-1:0] wr_addr,
    input  logic [OUTW-1:0]  wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [OUTW-1:0]  OUT_AXIS_TDATA,
    output logic             OUT_AXIS_TVALID,
    input  logic             OUT_AXIS_TREADY,
    output logic             OUT_AXIS_TLAST
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state_q;
    logic             busy_q, done_q, inflight_q;
    logic [ADDRW:0]   rd_cnt_q;
    logic [ADDRW-1:0] beat_q;
    logic [1:0]       cnt_q;
    logic [OUTW-1:0]  buf0_q, buf1_q, rdata_q;
    logic [OUTW-1:0]  mem [NUM];
    logic             hs, rd_en, wr_ok, last_beat, last_flag;
    logic [2:0]       occ;

    assign hs        = OUT_AXIS_TVALID && OUT_AXIS_TREADY;
    assign last_beat = beat_q == ADDRW'(NUM - 1);
    // a slot freed by this cycle's handshake may be refilled immediately
    assign occ       = 3'(cnt_q) + 3'(inflight_q) - 3'(hs);
    assign rd_en     = state_q == STREAM && rd_cnt_q < (ADDRW + 1)'(NUM) && occ < 3'd2;
    assign wr_ok     = state_q == IDLE && wr_en && {1'b0, wr_addr} < (ADDRW + 1)'(NUM);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr] <= wr_data;
        if (rd_en) rdata_q <= mem[rd_cnt_q[ADDRW-1:0]];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            rd_cnt_q   <= '0;
            beat_q     <= '0;
            cnt_q      <= '0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= rd_en;
            if (state_q == IDLE) begin
                if (start) begin
                    state_q  <= STREAM;
                    busy_q   <= 1'b1;
                    rd_cnt_q <= '0;
                    beat_q   <= '0;
                end
            end else if (hs && last_beat) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
            if (rd_en) rd_cnt_q <= rd_cnt_q + (ADDRW + 1)'(1);
            if (hs) beat_q <= last_beat ? '0 : beat_q + ADDRW'(1);
            if (hs) buf0_q <= (inflight_q && cnt_q == 2'd1) ? rdata_q : buf1_q;
            else if (inflight_q && cnt_q == 2'd0) buf0_q <= rdata_q;
            if (inflight_q && ((cnt_q == 2'd1 && !hs) || (cnt_q == 2'd2 && hs))) buf1_q <= rdata_q;
            cnt_q <= cnt_q + 2'(inflight_q) - 2'(hs);
        end
    end

`ifdef MATRIX_STREAM_TX_ROW_TLAST_EN
    localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
    logic [CW-1:0] col_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) col_q <= '0;
        else if (state_q == IDLE) col_q <= '0;
        else if (hs) col_q <= (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
    end
    assign last_flag = col_q == CW'(COLS - 1);
`else
    assign last_flag = last_beat;
`endif

    assign OUT_AXIS_TVALID = cnt_q != 2'd0;
    assign OUT_AXIS_TDATA  = buf0_q;
    assign OUT_AXIS_TLAST  = OUT_AXIS_TVALID && last_flag;
    assign busy            = busy_q;
    assign done            = done_q;
endmodule

// File: tb/tb_matrix_stream_tx.sv
// tb_matrix_stream_tx: scoreboard bench for matrix_stream_tx (load, stream under several TREADY patterns, abort by reset).
module tb_matrix_stream_tx;
    localparam int OUTW = 24;
    localparam int NUM = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            wr_en = 1'b0;
    logic [3:0]      wr_addr = '0;
    logic [OUTW-1:0] wr_data = '0;
    logic            start = 1'b0;
    logic            busy, done;
    logic [OUTW-1:0] tdata;
    logic            tvalid, tlast;
    logic            tready = 1'b0;

    typedef struct {
        logic [OUTW-1:0] d;
        logic            l;
    } exp_t;

    exp_t            sb[$];
    logic [OUTW-1:0] model [NUM];
    int              checks = 0;
    int              errors = 0;

    matrix_stream_tx #(.OUTW(OUTW), .ROWS(4), .COLS(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .busy(busy), .done(done),
        .OUT_AXIS_TDATA(tdata), .OUT_AXIS_TVALID(tvalid),
        .OUT_AXIS_TREADY(tready), .OUT_AXIS_TLAST(tlast)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_matrix();
        exp_t e;
        for (int i = 0; i < NUM; i++) begin
            e.d = model[i];
`ifdef MATRIX_STREAM_TX_ROW_TLAST_EN
            e.l = (i % 4) == 3;
`else
            e.l = i == NUM - 1;
`endif
            sb.push_back(e);
        end
    endtask

    // mode 0: TREADY=1, 1: toggling, 2: 10-cycle stall, 3: TREADY=1 with start/write injected mid-stream
    task automatic xfer(input int mode, input int exp_cycles);
        int  cyc = 0;
        int  hsn = 0;
        bit  fin = 0;
        exp_t e;
        push_matrix();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_rise", 32'(busy), 1);
        chk("lat0_valid", 32'(tvalid), 0);
        step();
        chk("lat1_valid", 32'(tvalid), 0);
        step();
        chk("lat2_valid", 32'(tvalid), 1);
        while (!fin && cyc < 200) begin
            tready  = (mode == 1) ? (cyc % 2 == 0) : (mode == 2) ? (cyc >= 10) : 1'b1;
            start   = mode == 3 && cyc == 2;
            wr_en   = mode == 3 && cyc == 2;
            wr_addr = 4'd3;
            wr_data = 24'hABCDEF;
            if (mode != 1) chk("valid_held", 32'(tvalid), 1);
            chk("no_early_done", 32'(done), 0);
            if (tvalid) begin
                if (sb.size() == 0) chk("sb_empty", 32'(sb.size()), 1);
                else begin
                    chk("tdata", 32'(tdata), 32'(sb[0].d));
                    if (tready) begin
                        chk("tlast", 32'(tlast), 32'(sb[0].l));
                        e = sb.pop_front();
                        hsn++;
                        fin = hsn == NUM;
                    end
                end
            end
            step();
            cyc++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        chk("handshakes", 32'(hsn), NUM);
        chk("cycles", 32'(cyc), 32'(exp_cycles));
        chk("done_pulse", 32'(done), 1);
        chk("busy_fall", 32'(busy), 0);
        chk("valid_end", 32'(tvalid), 0);
        step();
        chk("done_one_cycle", 32'(done), 0);
        chk("no_restart", 32'(busy), 0);
    endtask

    initial begin
        int   cyc;
        int   hsn;
        exp_t e;
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(tvalid), 0);
        chk("rst_last", 32'(tlast), 0);
        chk("rst_data", 32'(tdata), 0);
        reset = 1'b1;
        step();
        for (int i = 0; i < NUM; i++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(i);
            wr_data = OUTW'(i + 1);
            model[i] = OUTW'(i + 1);
            step();
        end
        wr_en = 1'b0;
        xfer(0, 16);
        xfer(1, 31);
        xfer(2, 26);
        xfer(3, 16);
        xfer(0, 16);
        push_matrix();
        tready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        cyc = 0;
        hsn = 0;
        while (hsn < 5 && cyc < 50) begin
            if (tvalid && sb.size() > 0) begin
                chk("pre_rst_data", 32'(tdata), 32'(sb[0].d));
                e = sb.pop_front();
                hsn++;
            end
            step();
            cyc++;
        end
        chk("pre_rst_hs", 32'(hsn), 5);
        chk("pre_rst_valid", 32'(tvalid), 1);
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(tvalid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_last", 32'(tlast), 0);
        step();
        reset = 1'b1;
        chk("abort_no_done", 32'(done), 0);
        step();
        chk("abort_no_done2", 32'(done), 0);
        chk("abort_idle_valid", 32'(tvalid), 0);
        sb.delete();
        xfer(0, 16);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
